// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: recovers raster position from sync edges, checks timing,
// locks after clean frames, reports a frame checksum and a probe pixel. Option: VGA_MON_BLANK_CHECK_EN.
module vga_sync_monitor #(
  parameter int HPIXELS     = 800,
  parameter int VLINES      = 521,
  parameter int HPULSE      = 96,
  parameter int VPULSE      = 2,
  parameter int HBP         = 144,
  parameter int HFP         = 784,
  parameter int VBP         = 31,
  parameter int VFP         = 511,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  red,
  input  logic [2:0]  green,
  input  logic [1:0]  blue,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic        locked,
  output logic        sync_err,
  output logic [7:0]  err_count,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic        probe_valid,
  output logic [7:0]  probe_rgb
);

  typedef enum logic [1:0] {SEARCH = 2'd0, ALIGN = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [9:0]  HLAST_C  = 10'(HPIXELS - 1);
  localparam logic [9:0]  VLAST_C  = 10'(VLINES - 1);
  localparam logic [9:0]  HPULSE_C = 10'(HPULSE);
  localparam logic [9:0]  VPULSE_C = 10'(VPULSE);
  localparam logic [9:0]  HBP_C    = 10'(HBP);
  localparam logic [9:0]  HFP_C    = 10'(HFP);
  localparam logic [9:0]  VBP_C    = 10'(VBP);
  localparam logic [9:0]  VFP_C    = 10'(VFP);
  localparam logic [3:0]  LOCK_C   = 4'(LOCK_FRAMES);

  state_t      state_r, state_s;
  logic [3:0]  good_r, good_s;
  logic [9:0]  hcnt_r, vcnt_r, hcnt_s, vcnt_s;
  logic        prev_hs_r, prev_vs_r;
  logic [15:0] acc_r, acc_s;
  logic        hs_fall_s, hs_rise_s, vs_fall_s, vs_rise_s;
  logic        viol_s, blank_err_s, active_s, probe_hit_s;
  logic [7:0]  rgb_s;
  logic [10:0] probe_hx_s, probe_vy_s;

  // Edge detection and next raster position from the current sample
  always_comb begin
    rgb_s     = {red, green, blue};
    hs_fall_s = prev_hs_r & ~hsync;
    hs_rise_s = ~prev_hs_r & hsync;
    vs_fall_s = prev_vs_r & ~vsync;
    vs_rise_s = ~prev_vs_r & vsync;
    if (hs_fall_s) begin
      hcnt_s = 10'd0;
    end else if (hcnt_r == 10'd1023) begin
      hcnt_s = hcnt_r;
    end else begin
      hcnt_s = hcnt_r + 10'd1;
    end
    if (!hs_fall_s) begin
      vcnt_s = vcnt_r;
    end else if (vs_fall_s) begin
      vcnt_s = 10'd0;
    end else if (vcnt_r == 10'd1023) begin
      vcnt_s = vcnt_r;
    end else begin
      vcnt_s = vcnt_r + 10'd1;
    end
  end

  // Active area, checksum, probe match and timing violation detection
  always_comb begin
    active_s   = (hcnt_s >= HBP_C) && (hcnt_s < HFP_C) && (vcnt_s >= VBP_C) && (vcnt_s < VFP_C);
    acc_s      = acc_r + (active_s ? {8'd0, rgb_s} : 16'd0);
    probe_hx_s = 11'(HBP) + {1'b0, probe_x};
    probe_vy_s = 11'(VBP) + {1'b0, probe_y};
    // 11-bit compare keeps out-of-range probe coordinates from aliasing into the active area
    probe_hit_s = (state_r == LOCKED) && active_s &&
                  ({1'b0, hcnt_s} == probe_hx_s) && ({1'b0, vcnt_s} == probe_vy_s);
`ifdef VGA_MON_BLANK_CHECK_EN
    blank_err_s = !active_s && (rgb_s != 8'd0);
`else
    blank_err_s = 1'b0;
`endif
    viol_s = (hs_fall_s && (hcnt_r != HLAST_C)) ||
             (hs_rise_s && (hcnt_s != HPULSE_C)) ||
             (vs_fall_s && (vcnt_r != VLAST_C)) ||
             (vs_rise_s && (vcnt_s != VPULSE_C)) ||
             ((vs_fall_s || vs_rise_s) && !hs_fall_s) ||
             blank_err_s;
  end

  // Lock FSM next state
  always_comb begin
    state_s = state_r;
    good_s  = good_r;
    if (pix_en) begin
      case (state_r)
        SEARCH: begin
          if (vs_fall_s) begin
            state_s = ALIGN;
            good_s  = 4'd0;
          end else begin
            state_s = SEARCH;
          end
        end
        ALIGN: begin
          if (viol_s) begin
            state_s = SEARCH;
          end else if (vs_fall_s) begin
            good_s = good_r + 4'd1;
            if ((good_r + 4'd1) == LOCK_C) begin
              state_s = LOCKED;
            end else begin
              state_s = ALIGN;
            end
          end else begin
            state_s = ALIGN;
          end
        end
        LOCKED: begin
          if (viol_s) begin
            state_s = SEARCH;
          end else begin
            state_s = LOCKED;
          end
        end
        default: begin
          state_s = SEARCH;
          good_s  = 4'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Raster counters, sync history and FSM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_r    <= 10'd0;
      vcnt_r    <= 10'd0;
      prev_hs_r <= 1'b1;
      prev_vs_r <= 1'b1;
      state_r   <= SEARCH;
      good_r    <= 4'd0;
    end else if (pix_en) begin
      hcnt_r    <= hcnt_s;
      vcnt_r    <= vcnt_s;
      prev_hs_r <= hsync;
      prev_vs_r <= vsync;
      state_r   <= state_s;
      good_r    <= good_s;
    end
  end

  // Registered status, error count, checksum and probe outputs; pulses drop on idle cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      err_count   <= 8'd0;
      frame_done  <= 1'b0;
      frame_sum   <= 16'd0;
      acc_r       <= 16'd0;
      probe_valid <= 1'b0;
      probe_rgb   <= 8'd0;
    end else if (pix_en) begin
      locked      <= (state_s == LOCKED);
      sync_err    <= viol_s && (state_r != SEARCH);
      frame_done  <= vs_fall_s;
      probe_valid <= probe_hit_s;
      if (viol_s && (state_r == LOCKED) && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
      if (vs_fall_s) begin
        frame_sum <= acc_s;
        acc_r     <= 16'd0;
      end else begin
        acc_r     <= acc_s;
      end
      if (probe_hit_s) begin
        probe_rgb <= rgb_s;
      end
    end else begin
      sync_err    <= 1'b0;
      frame_done  <= 1'b0;
      probe_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Randomized self-checking bench for vga_sync_monitor on a reduced raster (40x24 lines),
// with a frame-level reference model driven by the bench's own knowledge of injected faults.
`timescale 1ns/1ps
module tb_vga_sync_monitor;

  localparam int HP = 40, VL = 24, HPU = 6, VPU = 2;
  localparam int HB = 10, HF = 34, VB = 4, VF = 20, LF = 2;
  localparam int F_NONE = 0, F_SHORT = 1, F_NARROW = 2, F_BLANK = 3, F_RESET = 4;
`ifdef VGA_MON_BLANK_CHECK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, pix_en, hsync, vsync;
  logic [2:0]  red, green;
  logic [1:0]  blue;
  logic [9:0]  probe_x, probe_y;
  logic        locked, sync_err, frame_done, probe_valid;
  logic [7:0]  err_count, probe_rgb;
  logic [15:0] frame_sum;

  vga_sync_monitor #(
    .HPIXELS(HP), .VLINES(VL), .HPULSE(HPU), .VPULSE(VPU),
    .HBP(HB), .HFP(HF), .VBP(VB), .VFP(VF), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue), .probe_x(probe_x), .probe_y(probe_y),
    .locked(locked), .sync_err(sync_err), .err_count(err_count), .frame_done(frame_done),
    .frame_sum(frame_sum), .probe_valid(probe_valid), .probe_rgb(probe_rgb)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // reference model: 0 = searching, 1 = aligning, 2 = locked
  int          m_st, m_good, m_errs;
  logic [15:0] m_acc, m_fs;
  bit          m_acc_known, m_fs_known;
  logic [7:0]  m_prgb;

  int fault, fy, fx, rgb_mode, gap_fixed;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_good = 0; m_errs = 0;
    m_fs = 16'd0; m_fs_known = 1'b1; m_prgb = 8'd0;
  endtask

  task automatic check_outputs(input bit e_err, input bit e_fd, input bit e_pv);
    chk("sync_err",    {15'd0, sync_err},    {15'd0, e_err});
    chk("frame_done",  {15'd0, frame_done},  {15'd0, e_fd});
    chk("probe_valid", {15'd0, probe_valid}, {15'd0, e_pv});
    chk("locked",      {15'd0, locked},      {15'd0, (m_st == 2)});
    chk("err_count",   {8'd0, err_count},    16'(m_errs));
    chk("probe_rgb",   {8'd0, probe_rgb},    {8'd0, m_prgb});
    if (m_fs_known) chk("frame_sum", frame_sum, m_fs);
  endtask

  task automatic send_sample(input int x, input int y, input logic hs, input logic vs,
                             input logic [7:0] rgb, input bit viol);
    int gaps;
    bit vsf, act, pv, e_err;
    gaps = gap_fixed ? 3 : int'($urandom_range(0, 2));
    for (int i = 0; i < gaps; i++) begin
      @(negedge clk);
      pix_en = 1'b0; hsync = hs; vsync = vs; {red, green, blue} = 8'($urandom);
      @(posedge clk); #1;
      check_outputs(1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    pix_en = 1'b1; hsync = hs; vsync = vs; {red, green, blue} = rgb;
    @(posedge clk); #1;
    vsf   = (x == 0) && (y == 0);
    act   = (x >= HB) && (x < HF) && (y >= VB) && (y < VF);
    pv    = (m_st == 2) && act && (x == HB + int'(probe_x)) && (y == VB + int'(probe_y));
    e_err = viol && (m_st != 0);
    if (m_st == 0) begin
      if (vsf) begin m_st = 1; m_good = 0; end
    end else if (viol) begin
      if (m_st == 2 && m_errs < 255) m_errs++;
      m_st = 0;
    end else if (vsf && m_st == 1) begin
      m_good++;
      if (m_good == LF) m_st = 2;
    end
    if (act) m_acc = m_acc + 16'(rgb);
    if (vsf) begin
      m_fs = m_acc; m_fs_known = m_acc_known;
      m_acc = 16'd0; m_acc_known = 1'b1;
    end
    if (pv) m_prgb = rgb;
    check_outputs(e_err, vsf, pv);
  endtask

  task automatic mid_reset();
    @(posedge clk); #2;
    rst = 1'b1; pix_en = 1'b0;
    #1;
    chk("rst_locked",      {15'd0, locked},      16'd0);
    chk("rst_sync_err",    {15'd0, sync_err},    16'd0);
    chk("rst_err_count",   {8'd0, err_count},    16'd0);
    chk("rst_frame_done",  {15'd0, frame_done},  16'd0);
    chk("rst_frame_sum",   frame_sum,            16'd0);
    chk("rst_probe_valid", {15'd0, probe_valid}, 16'd0);
    chk("rst_probe_rgb",   {8'd0, probe_rgb},    16'd0);
    model_reset();
    m_acc_known = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_frame();
    int xlen;
    logic hs, vs;
    logic [7:0] rgb;
    bit viol, act;
    for (int y = 0; y < VL; y++) begin
      xlen = (fault == F_SHORT && y == fy) ? HP - 1 : HP;
      for (int x = 0; x < xlen; x++) begin
        hs   = (x < HPU) ? 1'b0 : 1'b1;
        vs   = (y < VPU) ? 1'b0 : 1'b1;
        act  = (x >= HB) && (x < HF) && (y >= VB) && (y < VF);
        viol = 1'b0;
        case (rgb_mode)
          0:       rgb = act ? 8'h01 : 8'h00;
          1:       rgb = act ? 8'($urandom) : 8'h00;
          default: rgb = (x == HB + int'(probe_x) && y == VB + int'(probe_y)) ? 8'hA5 : 8'h00;
        endcase
        if (fault == F_SHORT && y == fy + 1 && x == 0) viol = 1'b1;
        if (fault == F_NARROW && y == fy && x == HPU - 1) begin hs = 1'b1; viol = 1'b1; end
        if (fault == F_BLANK && y == fy && x == 5) begin rgb = 8'hFF; viol = BLANK_EN; end
        if (fault == F_RESET && y == fy && x == fx) mid_reset();
        send_sample(x, y, hs, vs, rgb, viol);
      end
    end
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1;
    red = 3'd0; green = 3'd0; blue = 2'd0;
    probe_x = 10'd23; probe_y = 10'd15;
    fault = F_NONE; fy = 0; fx = 0; rgb_mode = 0; gap_fixed = 1;
    model_reset();
    m_acc = 16'd0; m_acc_known = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // three ideal frames of constant colour: lock at the third frame start
    repeat (3) run_frame();
    chk("lock_after_3", {15'd0, locked}, 16'd1);
    chk("sum_const", frame_sum, 16'd384);

    // random colour and pixel-strobe spacing
    gap_fixed = 0; rgb_mode = 1;
    probe_x = 10'($urandom_range(0, HF - HB - 1));
    probe_y = 10'($urandom_range(0, VF - VB - 1));
    run_frame();

    // shortened line while locked, then relock
    fault = F_SHORT; fy = $urandom_range(3, VL - 3);
    run_frame();
    fault = F_NONE;
    chk("short_unlock", {15'd0, locked}, 16'd0);
    chk("short_errcnt", {8'd0, err_count}, 16'd1);
    repeat (3) run_frame();
    chk("short_relock", {15'd0, locked}, 16'd1);

    // hsync one pixel narrow
    fault = F_NARROW; fy = $urandom_range(3, VL - 2);
    run_frame();
    fault = F_NONE;
    chk("narrow_errcnt", {8'd0, err_count}, 16'd2);
    repeat (3) run_frame();

    // probe at the last active pixel, then an out-of-range column
    probe_x = 10'd23; probe_y = 10'd15; rgb_mode = 2;
    repeat (2) run_frame();
    chk("probe_a5", {8'd0, probe_rgb}, 16'h00A5);
    probe_x = 10'd24; probe_y = 10'd0;
    run_frame();

    // non-zero colour in horizontal blanking
    rgb_mode = 1;
    probe_x = 10'($urandom_range(0, HF - HB - 1));
    probe_y = 10'($urandom_range(0, VF - VB - 1));
    fault = F_BLANK; fy = $urandom_range(VB, VF - 1);
    run_frame();
    fault = F_NONE;
    chk("blank_lock", {15'd0, locked}, {15'd0, !BLANK_EN});

    // asynchronous reset mid-frame, then recovery
    fault = F_RESET; fy = $urandom_range(VB, VF - 1); fx = $urandom_range(HPU + 1, HP - 2);
    run_frame();
    fault = F_NONE;
    repeat (3) run_frame();
    chk("reset_relock", {15'd0, locked}, 16'd1);
    chk("reset_errcnt", {8'd0, err_count}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
